// File: rtl/fixed_float_pkg.sv
// rtl/fixed_float_pkg.sv - shared state encodings and float format helpers for the fixed-to-float converter
//
// Purpose : FSM state constants and IEEE-754 format derivation from the float width P.
// Contents: state_t, IDLE/LOAD/NORM/PACK/DONE, EW(P), MW(P), BIAS(P).
package fixed_float_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t LOAD = 3'd1;
    localparam state_t NORM = 3'd2;
    localparam state_t PACK = 3'd3;
    localparam state_t DONE = 3'd4;

    // Only single (32) and double (64) precision are supported; anything else
    // falls back to single-precision field widths.
    function automatic int EW(input int p);
        return (p == 64) ? 11 : 8;
    endfunction

    function automatic int MW(input int p);
        return (p == 64) ? 52 : 23;
    endfunction

    function automatic int BIAS(input int p);
        return (p == 64) ? 1023 : 127;
    endfunction

endpackage

// File: rtl/float_round_pack.sv
// rtl/float_round_pack.sv - combinational pack of a normalised magnitude into an IEEE-754 word
//
// Purpose : {sign, normalised magnitude, shift count} -> P-bit float, with optional rounding.
// Macro   : ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the low bits are truncated.
// Ports   : i_sign  - sign of the original operand
//           i_mag   - magnitude, MSB set unless the operand was zero
//           i_shcnt - number of left shifts applied during normalisation
//           o_float - packed float result
module float_round_pack
    import fixed_float_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int P    = 32,
    parameter int SW   = $clog2(W)
) (
    input  logic          i_sign,
    input  logic [W-1:0]  i_mag,
    input  logic [SW-1:0] i_shcnt,
    output logic [P-1:0]  o_float
);

    localparam int LP_EW    = EW(P);
    localparam int LP_MW    = MW(P);
    localparam int LP_BIAS  = BIAS(P);
    // Exponent of a magnitude whose MSB sits at bit W-1 with no shifting.
    localparam int EXP_BASE = W - 1 - FRAC + LP_BIAS;
    // Bits below the hidden one, padded with MW+2 zeros so that the mantissa,
    // guard and sticky positions always exist even when W-1 < MW.
    localparam int XW       = W - 1 + LP_MW + 2;

    logic [XW-1:0]    w_ext;
    logic [LP_MW-1:0] w_mant;
    logic             w_inc;
    logic [LP_MW:0]   w_mant_sum;
    logic             w_carry;
    logic [LP_EW-1:0] w_exp;

    assign w_ext  = {i_mag[W-2:0], {(LP_MW + 2){1'b0}}};
    assign w_mant = w_ext[XW-1 -: LP_MW];

`ifdef ROUND_NEAREST_EN
    logic w_guard;
    logic w_sticky;

    assign w_guard  = w_ext[XW-1-LP_MW];
    assign w_sticky = |w_ext[XW-2-LP_MW:0];
    assign w_inc    = w_guard & (w_sticky | w_mant[0]);
`else
    assign w_inc    = 1'b0;
`endif

    // A carry out of the mantissa leaves the mantissa field at zero and bumps the exponent.
    assign w_mant_sum = {1'b0, w_mant} + {{LP_MW{1'b0}}, w_inc};
    assign w_carry    = w_mant_sum[LP_MW];
    assign w_exp      = LP_EW'(EXP_BASE) - LP_EW'(i_shcnt) + LP_EW'(w_carry);

    always_comb begin
        o_float = '0;
        if (i_mag != '0) begin
            o_float = {i_sign, w_exp, w_mant_sum[LP_MW-1:0]};
        end
    end

endmodule

// File: rtl/fixed_to_float_converter.sv
// rtl/fixed_to_float_converter.sv - multi-cycle signed fixed-point to IEEE-754 float converter
//
// Purpose : Converts FIXED (value FIXED * 2^-FRAC) to a P-bit float with a Begin/ACK handshake.
// Macro   : ROUND_NEAREST_EN (in float_round_pack) selects round-to-nearest-even vs truncation.
// Ports   : CLK          - clock, rising edge
//           RST_N        - asynchronous active-low reset
//           Begin_FSM_FF - start request, sampled only in IDLE
//           FIXED        - W-bit two's complement operand
//           ACK_FF       - conversion done, RESULT valid while high
//           BUSY_FF      - high during LOAD/NORM/PACK
//           RESULT       - P-bit float, held until the next PACK
module fixed_to_float_converter
    import fixed_float_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int P    = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         Begin_FSM_FF,
    input  logic [W-1:0] FIXED,
    output logic         ACK_FF,
    output logic         BUSY_FF,
    output logic [P-1:0] RESULT
);

    localparam int SW = $clog2(W);

    state_t        r_state;
    logic [W-1:0]  r_op;
    logic          r_sign;
    logic [W-1:0]  r_mag;
    logic [SW-1:0] r_shcnt;
    logic [P-1:0]  r_result;
    logic          r_ack;

    logic [W-1:0]  w_abs;
    logic [P-1:0]  w_packed;

    // Unsigned negate: the most negative input maps onto 2^(W-1) without overflow.
    assign w_abs = r_op[W-1] ? (~r_op + W'(1)) : r_op;

    float_round_pack #(
        .W    (W),
        .FRAC (FRAC),
        .P    (P),
        .SW   (SW)
    ) u_pack (
        .i_sign  (r_sign),
        .i_mag   (r_mag),
        .i_shcnt (r_shcnt),
        .o_float (w_packed)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_shcnt  <= '0;
            r_result <= '0;
            r_ack    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Begin_FSM_FF) begin
                        r_op    <= FIXED;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_sign  <= r_op[W-1];
                    r_mag   <= w_abs;
                    r_shcnt <= '0;
                    r_state <= NORM;
                end
                NORM: begin
                    if ((r_mag != '0) && !r_mag[W-1]) begin
                        r_mag   <= r_mag << 1;
                        r_shcnt <= r_shcnt + SW'(1);
                    end else begin
                        r_state <= PACK;
                    end
                end
                PACK: begin
                    r_result <= w_packed;
                    r_state  <= DONE;
                end
                DONE: begin
                    // ACK is registered, so it rises one edge after entering DONE and
                    // the release is only honoured once ACK has actually been shown.
                    r_ack <= 1'b1;
                    if (r_ack && !Begin_FSM_FF) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ACK_FF  = r_ack;
    assign BUSY_FF = (r_state == LOAD) || (r_state == NORM) || (r_state == PACK);
    assign RESULT  = r_result;

endmodule
